// File: rtl/hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard control unit.
package hazard_pkg;

  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    RUN           = 2'd0,
    TRAP_DRAIN    = 2'd1,
    TRAP_REDIRECT = 2'd2
  } state_t;

  localparam logic [1:0] PCSEL_SEQ  = 2'b00;
  localparam logic [1:0] PCSEL_EX   = 2'b01;
  localparam logic [1:0] PCSEL_TRAP = 2'b10;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use hazard detection between the ID instruction and a load in EX.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              ex_memRead,
  input  logic [REG_AW-1:0] ex_rd_addr,
  output logic              lu
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
    rs2_hit = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
    // x0 is never a real dependency
    lu      = ex_memRead && (ex_rd_addr != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline control: load-use bubbles, redirect squash, trap flush/drain/redirect
// sequencing, plus stall and flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              ex_memRead,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_redirect,
  input  logic              ex_trapReq,
  output logic              pc_write,
  output logic [1:0]        pc_sel,
  output logic              IFID_write,
  output logic              ifid_flush,
  output logic              IDEX_write,
  output logic              flush_branch,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  state_t     state;
  logic [3:0] drain_cnt;
  logic       lu;

  load_use_detect u_lu (
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_memRead  (ex_memRead),
    .ex_rd_addr  (ex_rd_addr),
    .lu          (lu)
  );

  assign busy = (state != RUN);

  always_comb begin
    pc_write     = 1'b0;
    pc_sel       = PCSEL_SEQ;
    IFID_write   = 1'b0;
    ifid_flush   = 1'b0;
    IDEX_write   = 1'b0;
    flush_branch = 1'b0;
    if (reset) begin
      unique case (state)
        RUN: begin
          if (ex_trapReq) begin
            ifid_flush   = 1'b1;
            flush_branch = 1'b1;
          end else if (ex_redirect) begin
            pc_write     = 1'b1;
            pc_sel       = PCSEL_EX;
            IFID_write   = 1'b1;
            ifid_flush   = 1'b1;
            flush_branch = 1'b1;
          end else if (!lu) begin
            pc_write   = 1'b1;
            IFID_write = 1'b1;
            IDEX_write = 1'b1;
          end
        end
        TRAP_DRAIN: begin
          ifid_flush   = 1'b1;
          flush_branch = 1'b1;
        end
        TRAP_REDIRECT: begin
          pc_write     = 1'b1;
          pc_sel       = PCSEL_TRAP;
          ifid_flush   = 1'b1;
          flush_branch = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      drain_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (ex_trapReq) begin
            // The trap cycle itself is the first of the DRAIN_CYCLES
            state     <= (DRAIN_CYCLES <= 1) ? TRAP_REDIRECT : TRAP_DRAIN;
            drain_cnt <= 4'(DRAIN_CYCLES - 1);
            flush_cnt <= flush_cnt + CNT_W'(1);
          end else if (ex_redirect) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
          end else if (lu) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
          end
        end
        TRAP_DRAIN: begin
          drain_cnt <= drain_cnt - 4'd1;
          if (drain_cnt <= 4'd1) state <= TRAP_REDIRECT;
        end
        TRAP_REDIRECT: state <= RUN;
        default:       state <= RUN;
      endcase
    end
  end

endmodule
